rns_to_bin: RTL and testbench

Sequential reverse converter that turns a packed 4-residue RNS word back into a 32-bit binary integer using mixed-radix conversion (MRC). It sits on the output side of the RNS filter datapath and decodes each `y_rns` word read out of the filter for host and binary-domain consumers. It is the decoder counterpart to the binary-to-RNS encoder, and uses the same moduli `B3..B0` from `common.sv`. Valid/ready handshakes on both sides; one conversion in flight at a time.

---
 rtl/rns_pkg.sv | 62 ++++++
 rtl/rns_mrc_digit.sv | 40 ++++
 rtl/rns_to_bin.sv | 142 ++++++++++++++
 tb/tb_rns_to_bin.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/rns_pkg.sv
// Shared constants for the RNS reverse converter: moduli, dynamic range,
// MRC modular inverses and the controller state type.
package rns_pkg;

  // Moduli, channel 0..3 (r0 mod B0 ... r3 mod B3).
  localparam int B0 = 251;
  localparam int B1 = 253;
  localparam int B2 = 255;
  localparam int B3 = 256;

  localparam longint M_L = longint'(B0) * B1 * B2 * B3;
  localparam logic [31:0] M    = 32'(M_L);
  localparam logic [31:0] HALF = 32'((M_L + 1) / 2);

  // Extended Euclid: a^-1 mod m (a and m coprime).
  function automatic int modinv(input int a, input int m);
    int t, nt, r, nr, q, tmp;
    t = 0; nt = 1; r = m; nr = a % m;
    while (nr != 0) begin
      q   = r / nr;
      tmp = t - q * nt; t = nt; nt = tmp;
      tmp = r - q * nr; r = nr; nr = tmp;
    end
    if (t < 0) t = t + m;
    return t;
  endfunction

  // inv(mj mod mi), j < i
  localparam int INV10 = modinv(B0 % B1, B1);
  localparam int INV20 = modinv(B0 % B2, B2);
  localparam int INV21 = modinv(B1 % B2, B2);
  localparam int INV30 = modinv(B0 % B3, B3);
  localparam int INV31 = modinv(B1 % B3, B3);
  localparam int INV32 = modinv(B2 % B3, B3);

  function automatic int mod_of(input int i);
    case (i)
      0:       return B0;
      1:       return B1;
      2:       return B2;
      default: return B3;
    endcase
  endfunction

  // Inverse used by channel i in digit step j+1; 0 where the channel is idle.
  function automatic int inv_of(input int i, input int j);
    case (i * 4 + j)
      4:       return INV10;
      8:       return INV20;
      9:       return INV21;
      12:      return INV30;
      13:      return INV31;
      14:      return INV32;
      default: return 0;
    endcase
  endfunction

  typedef enum logic [2:0] {
    S_IDLE, S_DIG1, S_DIG2, S_DIG3, S_HOR, S_FIX, S_OUT
  } state_t;

endpackage

// File: rtl/rns_mrc_digit.sv
// One MRC channel: ((r - a) * inv) mod MOD, inverse chosen by digit step.
module rns_mrc_digit #(
  parameter int MOD  = 253,
  parameter int INV1 = 0,
  parameter int INV2 = 0,
  parameter int INV3 = 0
) (
  input  logic [1:0] i_step,
  input  logic [7:0] i_r,
  input  logic [7:0] i_a,
  output logic [7:0] o_d
);
  localparam logic [8:0] LM = 9'(MOD);

  logic [7:0]  w_inv;
  logic [8:0]  w_ar;
  logic [8:0]  w_diff;
  logic [16:0] w_prod;

  // Select the inverse of the modulus being peeled off in this step.
  always_comb begin
    w_inv = '0;
    case (i_step)
      2'd1:    w_inv = 8'(INV1);
      2'd2:    w_inv = 8'(INV2);
      2'd3:    w_inv = 8'(INV3);
      default: w_inv = '0;
    endcase
  end

  // Previous digit may come from a smaller channel; reduce it, then subtract
  // with MOD added first so the difference never goes negative.
  always_comb begin
    w_ar   = {1'b0, i_a} % LM;
    w_diff = 9'((10'(i_r) + 10'(LM) - 10'(w_ar)) % 10'(LM));
    w_prod = 17'(w_diff) * 17'(w_inv);
    o_d    = 8'(w_prod % 17'(LM));
  end

endmodule

// File: rtl/rns_to_bin.sv
// Sequential RNS -> binary converter (mixed-radix digits, Horner rebuild,
// optional signed fold). One word in flight; valid/ready on both sides.
module rns_to_bin
  import rns_pkg::*;
#(
  parameter int SIGNED = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x_rns,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y
);
  state_t           r_state, w_next;
  logic [1:0]       r_cnt;
  logic [3:0][7:0]  r_res;
  logic [31:0]      r_acc;
  logic             r_neg;
  logic [31:0]      r_y;

  logic [1:0]       w_step;
  logic [7:0]       w_a;
  logic [2:0][7:0]  w_d;
  logic [7:0]       w_hb;
  logic [7:0]       w_ha;

  // Digit step index and the digit produced by the previous step.
  always_comb begin
    w_step = 2'd0;
    w_a    = r_res[0];
    case (r_state)
      S_DIG1:  begin w_step = 2'd1; w_a = r_res[0]; end
      S_DIG2:  begin w_step = 2'd2; w_a = r_res[1]; end
      S_DIG3:  begin w_step = 2'd3; w_a = r_res[2]; end
      default: begin w_step = 2'd0; w_a = r_res[0]; end
    endcase
  end

  for (genvar i = 1; i < 4; i++) begin : g_ch
    rns_mrc_digit #(
      .MOD (mod_of(i)),
      .INV1(inv_of(i, 0)),
      .INV2(inv_of(i, 1)),
      .INV3(inv_of(i, 2))
    ) u_dig (
      .i_step(w_step),
      .i_r   (r_res[i]),
      .i_a   (w_a),
      .o_d   (w_d[i-1])
    );
  end

  // Horner operands: radix and digit per step (a2/B2, a1/B1, a0/B0).
  always_comb begin
    w_hb = 8'(B0);
    w_ha = r_res[0];
    case (r_cnt)
      2'd0:    begin w_hb = 8'(B2); w_ha = r_res[2]; end
      2'd1:    begin w_hb = 8'(B1); w_ha = r_res[1]; end
      default: begin w_hb = 8'(B0); w_ha = r_res[0]; end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;

  // Next-state logic; HOR runs 3 cycles, FIX 2 (compare, then load y).
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next = S_DIG1;
      S_DIG1:  w_next = S_DIG2;
      S_DIG2:  w_next = S_DIG3;
      S_DIG3:  w_next = S_HOR;
      S_HOR:   if (r_cnt == 2'd2) w_next = S_FIX;
      S_FIX:   if (r_cnt == 2'd1) w_next = S_OUT;
      S_OUT:   if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_OUT);
    y         = r_y;
  end

  // Datapath: capture/reduce, digit steps, Horner, sign fold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      r_res <= '0;
      r_acc <= '0;
      r_neg <= 1'b0;
      r_y   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_res[0] <= 8'(32'(x_rns[7:0])   % B0);
          r_res[1] <= 8'(32'(x_rns[15:8])  % B1);
          r_res[2] <= 8'(32'(x_rns[23:16]) % B2);
          r_res[3] <= 8'(32'(x_rns[31:24]) % B3);
          r_cnt    <= '0;
        end
        S_DIG1: begin
          r_res[1] <= w_d[0];
          r_res[2] <= w_d[1];
          r_res[3] <= w_d[2];
        end
        S_DIG2: begin
          r_res[2] <= w_d[1];
          r_res[3] <= w_d[2];
        end
        S_DIG3: begin
          r_res[3] <= w_d[2];
          r_acc    <= 32'(w_d[2]);
        end
        S_HOR: begin
          r_acc <= 32'(r_acc * 32'(w_hb)) + 32'(w_ha);
          r_cnt <= (r_cnt == 2'd2) ? 2'd0 : r_cnt + 2'd1;
        end
        S_FIX: begin
          if (r_cnt == 2'd0) begin
            r_neg <= (SIGNED != 0) && (r_acc >= HALF);
            r_cnt <= 2'd1;
          end else begin
            r_y   <= r_neg ? (r_acc - M) : r_acc;
            r_cnt <= 2'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rns_to_bin.sv
// Scoreboard bench for rns_to_bin: signed and unsigned instances run in
// lockstep; expected results are queued at accept and checked on output.
module tb_rns_to_bin;

  typedef struct packed {
    logic [31:0] ys;
    logic [31:0] yu;
  } exp_t;

  localparam longint ML = 64'd4145475840;
  localparam longint HL = 64'd2072737920;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] x_rns = '0;
  logic        out_ready = 1'b1;
  logic        in_ready, out_valid, in_ready_u, out_valid_u;
  logic [31:0] y, y_u;

  int   checks = 0, failures = 0, n_sent = 0, n_recv = 0;
  bit   rnd_en = 1'b0;
  exp_t q[$];

  always #5 clk = ~clk;

  rns_to_bin #(.SIGNED(1)) dut (
    .clk(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x_rns(x_rns), .out_valid(out_valid), .out_ready(out_ready), .y(y));

  rns_to_bin #(.SIGNED(0)) dut_u (
    .clk(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(in_ready_u),
    .x_rns(x_rns), .out_valid(out_valid_u), .out_ready(out_ready), .y(y_u));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Call at #1 after a rising edge; returns at #1 after the accept edge.
  task automatic send(input logic [31:0] x, input logic [31:0] ys, input logic [31:0] yu);
    int t = 0;
    while (!in_ready && t < 200) begin @(posedge clk); #1; t++; end
    if (!in_ready) begin
      chk("send_timeout", 32'(in_ready), 32'd1);
    end else begin
      in_valid = 1'b1; x_rns = x;
      @(posedge clk);
      q.push_back('{ys, yu}); n_sent++;
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
  endtask

  // Monitor: one pop per output handshake.
  initial forever begin
    @(negedge clk);
    if (rst_n && out_valid && out_ready) begin
      chk("valid_lockstep", 32'(out_valid_u), 32'd1);
      if (q.size() == 0) begin
        chk("unexpected_output", y, 32'hDEAD_BEEF);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("y_signed", y, e.ys);
        chk("y_unsigned", y_u, e.yu);
        n_recv++;
      end
    end
  end

  // Random consumer stalls during the sweep.
  initial forever begin
    @(posedge clk); #1;
    if (rnd_en) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    int lat;
    longint xv;
    logic [31:0] es;

    #12 chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_y", y, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1000 with latency check
    send({8'd232, 8'd235, 8'd241, 8'd247}, 32'd1000, 32'd1000);
    wait_valid(lat);
    chk("latency_1000", 32'(lat), 32'd8);
    @(posedge clk); #1;

    send({8'd0, 8'd0, 8'd0, 8'd0}, 32'd0, 32'd0);
    send({8'd255, 8'd254, 8'd252, 8'd250}, 32'hFFFF_FFFF, 32'd4145475839);
    send({8'd127, 8'd254, 8'd252, 8'd250}, 32'd2072737919, 32'd2072737919);
    send({8'd128, 8'd0, 8'd0, 8'd0}, -32'sd2072737920, 32'd2072737920);
    send({8'd1, 8'd1, 8'd254, 8'd252}, 32'd1, 32'd1);     // non-canonical r1, r0
    send({8'd0, 8'd1, 8'd3, 8'd5}, 32'd256, 32'd256);

    // Backpressure: hold -1000 for 20 cycles with ignored in_valid pulses
    wait_valid(lat);
    @(posedge clk); #1;
    while (out_valid) begin @(posedge clk); #1; end
    out_ready = 1'b0;
    send({8'd24, 8'd20, 8'd12, 8'd4}, -32'sd1000, 32'd4145474840);
    wait_valid(lat);
    chk("latency_stall", 32'(lat), 32'd8);
    for (int i = 0; i < 20; i++) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_y", y, -32'sd1000);
      in_valid = (i % 3 == 0);
      x_rns = 32'h0102_0304;
      @(posedge clk); #1;
    end
    in_valid = 1'b1; x_rns = 32'h0102_0304; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("release_in_ready", 32'(in_ready), 32'd1);
    chk("release_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("no_accept_on_release", 32'(in_ready), 32'd1);
    send({8'd5, 8'd5, 8'd5, 8'd5}, 32'd5, 32'd5);
    wait_valid(lat);
    chk("latency_after_release", 32'(lat), 32'd8);
    @(posedge clk); #1;

    // Reset during DIG2
    send({8'd232, 8'd235, 8'd241, 8'd247}, 32'd1000, 32'd1000);
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_y", y, 32'd0);
    q.delete(); n_sent--;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    send({8'd232, 8'd235, 8'd241, 8'd247}, 32'd1000, 32'd1000);
    wait_valid(lat);
    chk("latency_after_reset", 32'(lat), 32'd8);
    @(posedge clk); #1;

    // Random sweep
    rnd_en = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      xv = longint'({$urandom}) % ML;
      es = (xv >= HL) ? 32'(xv - ML) : 32'(xv);
      send({8'(xv % 256), 8'(xv % 255), 8'(xv % 253), 8'(xv % 251)}, es, 32'(xv));
    end
    rnd_en = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 100 && q.size() != 0; t++) begin @(posedge clk); #1; end
    chk("queue_drained", 32'(q.size()), 32'd0);
    chk("recv_count", 32'(n_recv), 32'(n_sent));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
